// File: rtl/vsum3_lbuf.sv
// Three-row vertical summer for raster pixel streams.
// Two line buffers supply the pixels above the current one; results appear 2 cycles after the pixel.
module vsum3_lbuf #(
    parameter int DATA_W = 8,
    parameter int COLS   = 4,
    parameter int ROWS   = 5,
    parameter int MODE   = 0,
    localparam int CW    = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
    localparam int RW    = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pi_sof,
    input  logic              pi_flag,
    input  logic [DATA_W-1:0] pi_data,
    output logic              po_flag,
    output logic [DATA_W+1:0] po_sum,
    output logic [CW-1:0]     po_col,
    output logic [RW-1:0]     po_row,
    output logic              po_eof
);

    localparam logic [DATA_W+1:0] SUM_MAX = {2'b00, {DATA_W{1'b1}}};

    logic [CW-1:0]     col_q, cur_col;
    logic [RW-1:0]     row_q, cur_row;
    logic              last_col, last_row;
    logic [DATA_W-1:0] lb1 [COLS];
    logic [DATA_W-1:0] lb2 [COLS];
    logic [DATA_W-1:0] rd1, rd2;

    logic              s1_valid, s1_eof;
    logic [DATA_W-1:0] s1_pix, s1_up1, s1_up2;
    logic [CW-1:0]     s1_col;
    logic [RW-1:0]     s1_row;

    logic              s2_valid, s2_eof;
    logic [DATA_W+1:0] s2_sum, sat_sum;
    logic [CW-1:0]     s2_col;
    logic [RW-1:0]     s2_row;

    // Start of frame overrides the stored position for the pixel arriving this cycle.
    always_comb begin
        cur_col  = pi_sof ? '0 : col_q;
        cur_row  = pi_sof ? '0 : row_q;
        last_col = (cur_col == CW'(COLS - 1));
        last_row = (cur_row == RW'(ROWS - 1));
        rd1      = lb1[cur_col];
        rd2      = lb2[cur_col];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pi_flag) begin
            col_q <= last_col ? '0 : cur_col + 1'b1;
            if (last_col)
                row_q <= last_row ? '0 : cur_row + 1'b1;
            else
                row_q <= cur_row;
        end else if (pi_sof) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

    // Line buffers are never cleared; rows 0 and 1 never produce a result, so stale data is harmless.
    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            lb2[cur_col] <= rd1;
            lb1[cur_col] <= pi_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s1_eof   <= 1'b0;
            s1_pix   <= '0;
            s1_up1   <= '0;
            s1_up2   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= pi_flag && (cur_row >= RW'(2));
            s1_eof   <= last_col && last_row;
            s1_pix   <= pi_data;
            s1_up1   <= rd1;
            s1_up2   <= rd2;
            s1_col   <= cur_col;
            s1_row   <= cur_row;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s2_valid <= 1'b0;
            s2_eof   <= 1'b0;
            s2_sum   <= '0;
            s2_col   <= '0;
            s2_row   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_eof   <= s1_eof;
            s2_sum   <= {2'b00, s1_pix} + {2'b00, s1_up1} + {2'b00, s1_up2};
            s2_col   <= s1_col;
            s2_row   <= s1_row;
        end
    end

    always_comb begin
        sat_sum = s2_sum;
        if (MODE == 1 && s2_sum > SUM_MAX)
            sat_sum = SUM_MAX;
    end

    // Sum and position hold their last value between result pulses.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            po_flag <= 1'b0;
            po_eof  <= 1'b0;
            po_sum  <= '0;
            po_col  <= '0;
            po_row  <= '0;
        end else begin
            po_flag <= s2_valid;
            po_eof  <= s2_valid && s2_eof;
            if (s2_valid) begin
                po_sum <= sat_sum;
                po_col <= s2_col;
                po_row <= s2_row;
            end
        end
    end

endmodule

// File: doc/vsum3_lbuf.md
# vsum3_lbuf

Parametrised three-row vertical summer for raster pixel streams. For every pixel at row r ≥ 2 it outputs the sum of that pixel and the two pixels directly above it, drawn from two internal line buffers. Frame size, data width and output mode (full-precision or saturating) are set by parameter, and an optional start-of-frame input resynchronises the counters. It sits between a pixel source and downstream filter/threshold stages, as the generalised successor of the fixed 4×5 FIFO-based sum controller.

## Interface
- DATA_W, 8, pixel width in bits (≥ 1)
- COLS, 4, pixels per row (≥ 2)
- ROWS, 5, rows per frame (≥ 3)
- MODE, 0, 0 = full-precision sum; 1 = sum saturated to 2^DATA_W−1
- CW = max(1, $clog2(COLS)) and RW = max(1, $clog2(ROWS)), derived localparams
- sys_clk  in  1  single clock; all logic on the rising edge
- sys_rst  in  1  asynchronous, active-high reset
- pi_sof  in  1  start of frame; resets position counters (see Operation)
- pi_flag  in  1  pixel valid; one pixel is accepted per cycle when high
- pi_data  in  DATA_W  pixel value; sampled only when pi_flag = 1
- po_flag  out  1  output valid, one-cycle pulse per result
- po_sum  out  DATA_W+2  vertical sum; upper 2 bits are 0 when MODE = 1
- po_col  out  CW  column index of the result
- po_row  out  RW  row index of the result (the current row, 2..ROWS−1)
- po_eof  out  1  high together with po_flag on the last result of a frame

## Operation
- Position counters col (0..COLS−1) and row (0..ROWS−1) advance on each accepted pixel. col wraps at COLS−1 and increments row; row wraps at ROWS−1. After pixel (ROWS−1, COLS−1) the next pixel is (0, 0).
- Two line buffers, each COLS × DATA_W. LB1 holds row r−1 and LB2 holds row r−2, both addressed by col.
- On each accepted pixel at column c:
  - read LB1[c] and LB2[c];
  - write LB2[c] ← old LB1[c] and LB1[c] ← pi_data.
  - Read-before-write at the same address is required.
- A result is produced only for row ≥ 2: sum = pi_data + LB1[c] + LB2[c], computed at DATA_W+2 bits with no overflow.
- Rows 0 and 1 produce no output. Each frame yields exactly (ROWS−2)·COLS results.
- MODE = 1: po_sum = min(sum, 2^DATA_W−1).
- po_eof = 1 on the result for (ROWS−1, COLS−1).
- pi_sof = 1 forces col = row = 0:
  - with pi_flag = 1, that pixel is (0, 0);
  - with pi_flag = 0, the next accepted pixel is (0, 0).
- pi_sof does not flush results already in the pipeline; they are still emitted.
- Line-buffer contents are never cleared. Stale data cannot reach the output, because the first two rows after any sof, wrap or reset produce no result.

## Timing
- Reset values:
  - po_flag = 0, po_sum = 0, po_col = 0, po_row = 0, po_eof = 0;
  - counters = 0 and all pipeline valids = 0.
- Latency is fixed at 2 cycles. A pixel accepted at edge N produces po_flag/po_sum/po_col/po_row/po_eof at edge N+2. The current pixel is pipelined internally, so pi_data need not be held.
- Throughput: one pixel per cycle. pi_flag may stay high for any run length or have arbitrary gaps, and the output pattern mirrors the input pattern delayed by 2.
- po_sum, po_col and po_row hold their last value when po_flag = 0.
- Reset asserted mid-frame:
  - all outputs go to their reset values immediately;
  - in-flight results are discarded;
  - the first pixel after release is (0, 0).
- There is no backpressure. The downstream stage must accept every po_flag pulse.

## Test plan
All scenarios use DATA_W=8, COLS=4, ROWS=5.
- Ramp frame, MODE=0, pi_data = 4·row+col+1 back-to-back: 12 results. (2,0) → 15; (4,3) → 48 with po_eof=1; each result exactly 2 cycles after its input.
- All pixels = 255: MODE=0 gives po_sum=765 (10-bit) for every result; MODE=1 gives po_sum=255.
- Ramp frame with pi_flag high every 3rd cycle: same 12 values as the first scenario, each po_flag exactly 2 cycles after its pixel, never two consecutive pulses.
- Two frames back-to-back, frame 2 pixels = frame 1 + 100: 24 results. Frame 2 (2,0) → 315, confirming no frame-1 data is used; po_eof=1 twice.
- pi_sof pulsed with the 8th pixel of a ramp frame: that pixel becomes (0,0). No po_flag appears until 8 further accepted pixels, then the sums follow the new frame numbering.
- sys_rst asserted for 1 cycle during row 3: outputs are 0 the same cycle; the next frame behaves identically to the first scenario.
